// File: rtl/cline_write_buffer_pkg.sv
// Shared types for the eviction write buffer at the default lc3b widths.
// Parametrised builds derive their own entry layout locally.
package cline_write_buffer_pkg;

  localparam int WB_ADDR_W   = 16;
  localparam int WB_LINE_W   = 128;
  localparam int WB_OFFSET_W = 4;
  localparam int WB_TAG_W    = WB_ADDR_W - WB_OFFSET_W;

  typedef enum logic {
    wb_idle  = 1'b0,
    wb_write = 1'b1
  } lc3b_wb_state;

  typedef struct packed {
    logic                 valid;
    logic [WB_TAG_W-1:0]  line_addr;
    logic [WB_LINE_W-1:0] data;
  } lc3b_wb_entry;

endpackage

// File: rtl/cline_wb_cam.sv
// Match array over the buffer ring: per-entry line match plus the index of the
// youngest match, where age is measured from the head pointer.
module cline_wb_cam #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 12,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0]            vld,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            probe,
  input  logic [IDX_W-1:0]            head,
  input  logic                        excl_en,
  input  logic [IDX_W-1:0]            excl_idx,
  output logic [DEPTH-1:0]            match,
  output logic [IDX_W-1:0]            idx
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign match[g] = vld[g] && (tags[g] == probe) &&
                      !(excl_en && (excl_idx == IDX_W'(g)));
  end

  logic [IDX_W-1:0] pos;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    idx = head;
    pos = head;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + IDX_W'(k);
      if (match[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/cline_write_buffer.sv
// Eviction write buffer: ring of dirty lines draining to pmem in FIFO order,
// with same-line write merging, read-after-evict lookup and explicit flush.
module cline_write_buffer
  import cline_write_buffer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_write_valid,
  output logic                       wb_write_ready,
  input  logic [ADDR_W-1:0]          wb_write_addr,
  input  logic [LINE_W-1:0]          wb_write_data,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [LINE_W-1:0]          lookup_data,
  input  logic                       drain_hold,
  input  logic                       flush,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       idle
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  line_addr;
    logic [LINE_W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0]            ents;
  logic [DEPTH-1:0]              ent_vld;
  logic [DEPTH-1:0][TAG_W-1:0]   ent_tag;
  logic [IDX_W-1:0]              head, tail, mrg_idx, lk_idx;
  logic [DEPTH-1:0]              mrg_match, lk_match;
  logic [CNT_W-1:0]              count_nxt;
  lc3b_wb_state                  state, state_nxt;
  logic                          flush_active, full, mrg_hit;
  logic                          push, push_new, push_merge, pop, start_ok, start;
  logic [TAG_W-1:0]              wr_tag;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    assign ent_vld[g] = ents[g].valid;
    assign ent_tag[g] = ents[g].line_addr;
  end

  assign wr_tag = wb_write_addr[ADDR_W-1:OFFSET_W];

  // The head being written to memory must not absorb a merge: its data is
  // already latched into pmem_wdata.
  cline_wb_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_mrg_cam (
    .vld(ent_vld), .tags(ent_tag), .probe(wr_tag), .head(head),
    .excl_en(state == wb_write), .excl_idx(head),
    .match(mrg_match), .idx(mrg_idx)
  );

  cline_wb_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_lk_cam (
    .vld(ent_vld), .tags(ent_tag), .probe(lookup_addr[ADDR_W-1:OFFSET_W]), .head(head),
    .excl_en(1'b0), .excl_idx(head),
    .match(lk_match), .idx(lk_idx)
  );

  assign mrg_hit        = |mrg_match;
  assign full           = (count == CNT_W'(DEPTH));
  assign wb_write_ready = !flush_active && (mrg_hit || !full);
  assign push           = wb_write_valid && wb_write_ready;
  assign push_merge     = push && mrg_hit;
  assign push_new       = push && !mrg_hit;
  assign pop            = (state == wb_write) && pmem_resp;
  assign count_nxt      = count + CNT_W'(push_new) - CNT_W'(pop);
  assign start_ok       = (count != '0) && (!drain_hold || flush_active || full);
  assign lookup_hit     = |lk_match;
  assign lookup_data    = lookup_hit ? ents[lk_idx].data : '0;
  assign idle           = (count == '0) && (state == wb_idle) && !flush_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= wb_idle;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      wb_idle: if (start_ok) begin
        state_nxt = wb_write;
        start     = 1'b1;
      end
      wb_write: if (pmem_resp) state_nxt = wb_idle;
      default:  state_nxt = wb_idle;
    endcase
  end

  always_comb pmem_write = (state == wb_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ents         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      flush_active <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (push_new) begin
        ents[tail].valid     <= 1'b1;
        ents[tail].line_addr <= wr_tag;
        ents[tail].data      <= wb_write_data;
        tail                 <= tail + 1'b1;
      end
      if (push_merge) ents[mrg_idx].data <= wb_write_data;
      if (pop) begin
        ents[head].valid <= 1'b0;
        head             <= head + 1'b1;
      end
      count        <= count_nxt;
      flush_active <= (flush_active || (flush && count != '0)) && (count_nxt != '0);
      // A merge into the head on the drain-start cycle must reach memory.
      if (start) begin
        pmem_address <= {ents[head].line_addr, {OFFSET_W{1'b0}}};
        pmem_wdata   <= (push_merge && mrg_idx == head) ? wb_write_data : ents[head].data;
      end
    end
  end

endmodule

// File: tb/tb_cline_write_buffer.sv
// Self-checking bench: directed scenarios then randomized traffic, every cycle
// compared against a queue-based model of the buffer.
module tb_cline_write_buffer;

  localparam int ADDR_W = 16, LINE_W = 128, OFFSET_W = 4, DEPTH = 4;
  localparam int TAG_W = ADDR_W - OFFSET_W;

  logic              clk = 1'b0, rst_n;
  logic              wb_write_valid, wb_write_ready, lookup_hit, drain_hold, flush;
  logic              pmem_write, pmem_resp, idle;
  logic [ADDR_W-1:0] wb_write_addr, lookup_addr, pmem_address;
  logic [LINE_W-1:0] wb_write_data, lookup_data, pmem_wdata;
  logic [2:0]        count;

  cline_write_buffer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_write_valid(wb_write_valid), .wb_write_ready(wb_write_ready),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .drain_hold(drain_hold), .flush(flush),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: q holds buffered lines oldest first; mw/ma/md describe the memory
  // write in flight; mf is the pending flush.
  logic [TAG_W-1:0]  mq_tag[$];
  logic [LINE_W-1:0] mq_dat[$];
  bit                mw, mf;
  logic [TAG_W-1:0]  ma;
  logic [LINE_W-1:0] md;

  task automatic cyc();
    int sz, mi, li;
    bit rdy, pop, start;
    @(negedge clk);
    sz = mq_tag.size();
    mi = -1;
    li = -1;
    for (int i = 0; i < sz; i++) begin
      if (mq_tag[i] == wb_write_addr[ADDR_W-1:OFFSET_W] && !(mw && i == 0)) mi = i;
      if (mq_tag[i] == lookup_addr[ADDR_W-1:OFFSET_W]) li = i;
    end
    rdy = !mf && (mi >= 0 || sz < DEPTH);
    chk("ready", LINE_W'(wb_write_ready), LINE_W'(rdy));
    chk("count", LINE_W'(count), LINE_W'(sz));
    chk("pmem_write", LINE_W'(pmem_write), LINE_W'(mw));
    if (mw) begin
      chk("pmem_address", LINE_W'(pmem_address), LINE_W'({ma, 4'h0}));
      chk("pmem_wdata", pmem_wdata, md);
    end
    chk("idle", LINE_W'(idle), LINE_W'(sz == 0 && !mw && !mf));
    chk("lookup_hit", LINE_W'(lookup_hit), LINE_W'(li >= 0));
    chk("lookup_data", lookup_data, (li >= 0) ? mq_dat[li] : '0);
    pop   = mw && pmem_resp;
    start = !mw && sz > 0 && (!drain_hold || mf || sz == DEPTH);
    if (wb_write_valid && rdy) begin
      if (mi >= 0) mq_dat[mi] = wb_write_data;
      else begin
        mq_tag.push_back(wb_write_addr[ADDR_W-1:OFFSET_W]);
        mq_dat.push_back(wb_write_data);
      end
    end
    if (start) begin
      mw = 1'b1;
      ma = mq_tag[0];
      md = mq_dat[0];
    end
    if (pop) begin
      void'(mq_tag.pop_front());
      void'(mq_dat.pop_front());
      mw = 1'b0;
    end
    mf = (mf || (flush && sz != 0)) && mq_tag.size() != 0;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    wb_write_valid = 1'b1;
    wb_write_addr  = a;
    wb_write_data  = d;
    cyc();
    wb_write_valid = 1'b0;
  endtask

  task automatic run(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      pmem_resp = (k % period == period - 1);
      cyc();
    end
    pmem_resp = 1'b0;
  endtask

  logic [ADDR_W-1:0] pool [4] = '{16'h1230, 16'h4560, 16'h7890, 16'hABC0};
  logic [LINE_W-1:0] dA, dB;

  initial begin
    int hold_pct;
    dA = {8{16'hAAAA}};
    dB = {8{16'hBBBB}};
    rst_n = 1'b0; wb_write_valid = 1'b0; wb_write_addr = '0; wb_write_data = '0;
    lookup_addr = 16'h1230; drain_hold = 1'b0; flush = 1'b0; pmem_resp = 1'b0;
    mw = 1'b0; mf = 1'b0; ma = '0; md = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", LINE_W'(wb_write_ready), LINE_W'(1));
    chk("rst_pmem_write", LINE_W'(pmem_write), '0);
    chk("rst_pmem_address", LINE_W'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_idle", LINE_W'(idle), LINE_W'(1));
    chk("rst_lookup_hit", LINE_W'(lookup_hit), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while a drain is in flight
    push(16'h1230, dA);
    push(16'h4560, dB);
    run(2, 100);
    chk("mid_write", LINE_W'(pmem_write), LINE_W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pmem_write", LINE_W'(pmem_write), '0);
    chk("arst_count", LINE_W'(count), '0);
    chk("arst_idle", LINE_W'(idle), LINE_W'(1));
    chk("arst_lk1230", LINE_W'(lookup_hit), '0);
    lookup_addr = 16'h4560;
    #1 chk("arst_lk4560", LINE_W'(lookup_hit), '0);
    mq_tag.delete(); mq_dat.delete(); mw = 1'b0; mf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // In-order drain after hold release
    drain_hold = 1'b1;
    push(16'h1230, dA);
    push(16'h4560, dB);
    drain_hold = 1'b0;
    run(10, 4);

    // Merge into a queued line, lookup by any offset
    drain_hold = 1'b1;
    push(16'h1230, dA);
    lookup_addr = 16'h123F;
    push(16'h1238, dB);
    drain_hold = 1'b0;
    run(6, 3);

    // Full buffer: new line refused, matching line merges, drain overrides hold
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(pool[i], {4{$urandom}});
    push(16'h2220, dA);
    push(16'h7894, dB);
    run(12, 3);
    drain_hold = 1'b0;
    run(4, 2);

    // Flush with three lines; pushes are refused while it runs
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(pool[i], {4{$urandom}});
    flush = 1'b1;
    cyc();
    wb_write_valid = 1'b1; wb_write_addr = 16'h5550; wb_write_data = dA;
    run(12, 3);
    wb_write_valid = 1'b0;
    run(2, 100);

    // Randomized traffic over a small line pool to force merges and overlaps
    hold_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) hold_pct = $urandom_range(0, 100);
      drain_hold     = ($urandom_range(0, 99) < hold_pct);
      wb_write_valid = $urandom_range(0, 1) == 1;
      wb_write_addr  = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
      wb_write_data  = {$urandom, $urandom, $urandom, $urandom};
      lookup_addr    = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
      flush          = ($urandom_range(0, 39) == 0);
      pmem_resp      = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cline_write_buffer.md
Name: cline_write_buffer

Overview:
- Parametrised eviction write buffer between the L1 data cache and physical memory.
- Holds up to DEPTH dirty cache lines so that an eviction does not stall the cache's miss-fill read.
- Lines drain to memory in FIFO order.
- Supports a combinational lookup for read-after-evict forwarding, and merges a new write into a pending write to the same line.
- Supports an explicit flush.

Parameters:
- ADDR_W, 16, byte-address width.
- LINE_W, 128, line width in bits (lc3b_cline at default).
- OFFSET_W, 4, low address bits ignored for line matching (log2 of bytes per line).
- DEPTH, 4, entry count; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_write_valid  in  1  cache presents an evicted line
- wb_write_ready  out  1  line accepted this cycle when valid and ready are both high
- wb_write_addr  in  ADDR_W  line address; offset bits are ignored
- wb_write_data  in  LINE_W  line data
- lookup_addr  in  ADDR_W  address probed by the cache on a miss
- lookup_hit  out  1  a buffered entry matches lookup_addr (combinational)
- lookup_data  out  LINE_W  data of the matching entry; 0 when there is no hit
- drain_hold  in  1  cache read miss in progress; defer starting a drain
- flush  in  1  single-cycle pulse: drain everything
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_W  head line address, offset bits forced to 0
- pmem_wdata  out  LINE_W  head line data
- pmem_resp  in  1  memory write complete
- count  out  $clog2(DEPTH+1)  number of valid entries
- idle  out  1  buffer empty, FSM in IDLE, no flush active

Behaviour:
- Storage is a ring of DEPTH entries, each {valid, line_addr, data}, with head and tail pointers and a count.
- Reset (asynchronous, any time, including mid-drain):
  - All valid bits, pointers, count and flush_active clear; FSM goes to IDLE.
  - pmem_write=0, pmem_address=0, pmem_wdata=0, wb_write_ready=1, lookup_hit=0, idle=1.
  - An in-flight memory write is abandoned.
- Line match: entry.line_addr == addr[ADDR_W-1:OFFSET_W].
- Merge:
  - A push whose line matches a valid entry that is not the head currently in WRITE overwrites that entry's data in place.
  - count does not change and the push is accepted even when the buffer is full.
- New entry:
  - Any other push is written at tail; tail increments modulo DEPTH and count increments.
  - Requires count < DEPTH at the start of the cycle. There is no same-cycle bypass of a pop.
- wb_write_ready = !flush_active && (merge_possible || count < DEPTH).
- Drain FSM:
  - IDLE -> WRITE when count>0 and at least one of !drain_hold, flush_active, or count==DEPTH holds. A full buffer or an active flush overrides drain_hold.
  - WRITE: pmem_write=1; pmem_address and pmem_wdata are registered from the head entry and held stable until pmem_resp.
  - WRITE + pmem_resp: clear the head's valid bit, advance head, decrement count, deassert pmem_write next cycle, go to IDLE.
  - The next drain may start the cycle after the return to IDLE.
- Push and pop in the same cycle: count stays the same; both pointers advance.
- Lookup:
  - Purely combinational over all valid entries, including the head in WRITE.
  - With multiple matches (draining head plus a newer entry), the youngest entry wins.
- Flush:
  - A flush pulse sets flush_active; it clears on the cycle count reaches 0.
  - While flush_active, pushes are refused. A flush with count==0 is a no-op.
  - A flush arriving while a flush is already active has no additional effect.
- idle = (count==0) && FSM==IDLE && !flush_active.

Decomposition:
- Add to lc3b_types:
  - lc3b_wb_state enum {wb_idle, wb_write}.
  - A packed struct lc3b_wb_entry {valid, line_addr, data}, sized from default widths.
- Parametrised variants use local typedefs in the module.
- One sub-module, cline_wb_cam: parametrised match array.
  - Inputs: entry array, probe address, head index, excluded entry index.
  - Outputs: per-entry match vector and youngest-match index.
  - Reused for both the merge check and the lookup.

Test Plan:
1. Reset mid-WRITE with two entries, then deassert rst_n -> pmem_write=0, count=0, idle=1, lookup_hit=0 for both addresses.
2. Push 0x1230/0xAAAA…, 0x4560/0xBBBB… with drain_hold=1, then release; pmem_resp after 3 cycles each -> writes appear in order: 0x1230 first, then 0x4560; count 2->1->0.
3. Push 0x1230 data A, then 0x1238 data B while 0x1230 is not at the head in WRITE -> count stays 1; the drained data is B; lookup_addr 0x123F returns B.
4. Fill 4 entries with drain_hold=1 -> ready=0 for a new address, ready=1 for a matching address; the drain starts despite drain_hold.
5. Pulse flush with 3 entries -> wb_write_ready=0 until count=0; 3 pmem writes occur; idle rises the cycle after the last pmem_resp.
6. Lookup 0x1230 while the head 0x1230 is in WRITE and a newer 0x1230 entry is queued -> lookup_data is the newer entry's data; pmem_wdata keeps the old data.
